// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - W-bit adder/subtractor, one CHUNK-bit ripple slice per pipeline stage, valid/ready stream
module pipelined_addsub #(
    parameter int W     = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         ovf
);
    localparam int STAGES = W / CHUNK;
    localparam int LAST   = STAGES - 1;

    logic [STAGES-1:0]          v_q;
    logic [STAGES-1:0]          c_q;
    logic [STAGES-1:0][W-1:0]   a_q;
    logic [STAGES-1:0][W-1:0]   b_q;
    logic [STAGES-1:0][W-1:0]   s_q;
    logic                       ovf_q;

    logic [STAGES-1:0]          src_v;
    logic [STAGES-1:0]          src_c;
    logic [STAGES-1:0][W-1:0]   src_a;
    logic [STAGES-1:0][W-1:0]   src_b;
    logic [STAGES-1:0][W-1:0]   src_s;
    logic [STAGES-1:0][W-1:0]   nxt_s;
    logic [STAGES-1:0][CHUNK:0] sum;
    logic                       nxt_ovf;
    logic                       advance;
    logic                       unused_tail;

    assign advance  = !v_q[LAST] || out_ready;
    assign in_ready = advance;

    // Stage 0 sees the operands after the subtract inversion; b is stored already inverted.
    assign src_v[0] = in_valid;
    assign src_a[0] = a;
    assign src_b[0] = sub ? ~b : b;
    assign src_c[0] = sub ? ~cin : cin;
    assign src_s[0] = '0;

    for (genvar k = 1; k < STAGES; k++) begin : g_link
        assign src_v[k] = v_q[k-1];
        assign src_a[k] = a_q[k-1];
        assign src_b[k] = b_q[k-1];
        assign src_c[k] = c_q[k-1];
        assign src_s[k] = s_q[k-1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        assign sum[k] = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                      + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, src_c[k]};
        assign nxt_s[k] = (src_s[k] & ~(W'({CHUNK{1'b1}}) << (k*CHUNK)))
                        | (W'(sum[k][CHUNK-1:0]) << (k*CHUNK));
    end

    assign nxt_ovf = (src_a[LAST][W-1] == src_b[LAST][W-1])
                  && (nxt_s[LAST][W-1] != src_a[LAST][W-1]);

    // The final stage's operand copies are never consumed downstream.
    assign unused_tail = ^{a_q[LAST], b_q[LAST]};

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            ovf_q <= 1'b0;
        end else if (advance) begin
            v_q <= src_v;
            // Bubbles shift the valid bit only, so idle cycles leave the data fields untouched.
            for (int k = 0; k < STAGES; k++) begin
                if (src_v[k]) begin
                    a_q[k] <= src_a[k];
                    b_q[k] <= src_b[k];
                    s_q[k] <= nxt_s[k];
                    c_q[k] <= sum[k][CHUNK];
                end
            end
            if (src_v[LAST]) begin
                ovf_q <= nxt_ovf;
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign s         = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - directed self-checking bench for pipelined_addsub (W=16, CHUNK=4)
module tb_pipelined_addsub;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        cout;
    logic        ovf;

    int total  = 0;
    int passed = 0;

    // Hand-computed vectors: expected = {s, cout, ovf}.
    logic [15:0] va [8] = '{16'h1234, 16'h0000, 16'hFFFF, 16'h8000, 16'h1000, 16'hABCD, 16'h7000, 16'h00FF};
    logic [15:0] vb [8] = '{16'h4321, 16'h0000, 16'hFFFF, 16'h8000, 16'h2000, 16'h1111, 16'h9000, 16'h0001};
    logic        vc [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        vs [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [17:0] vexp [8] = '{
        {16'h5556, 1'b0, 1'b0},
        {16'h0000, 1'b1, 1'b0},
        {16'hFFFF, 1'b1, 1'b0},
        {16'h0000, 1'b1, 1'b1},
        {16'hF000, 1'b0, 1'b0},
        {16'hBCDE, 1'b0, 1'b0},
        {16'hE000, 1'b0, 1'b1},
        {16'h0101, 1'b0, 1'b0}
    };

    pipelined_addsub #(.W(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] ta, input logic [15:0] tb2,
                         input logic tc, input logic ts);
        in_valid = v;
        a        = ta;
        b        = tb2;
        cin      = tc;
        sub      = ts;
    endtask

    task automatic one_beat(input logic [15:0] ta, input logic [15:0] tb2,
                            input logic tc, input logic ts, output int lat);
        drive(1'b1, ta, tb2, tc, ts);
        tick();
        drive(1'b0, 16'hDEAD, 16'hBEEF, 1'b1, 1'b1);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        out_ready = 1'b0;
        drive(1'b1, 16'h1111, 16'h2222, 1'b1, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if (s !== 16'h0000) $display("FAIL reset_s got %h want 0000", s); else passed++;
        total++; if (cout !== 1'b0) $display("FAIL reset_cout got %b want 0", cout); else passed++;
        total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_directed(input string name, input logic [15:0] ta, input logic [15:0] tb2,
                                 input logic tc, input logic ts, input logic [17:0] exp);
        int lat;
        out_ready = 1'b1;
        one_beat(ta, tb2, tc, ts, lat);
        total++; if (lat !== 4) $display("FAIL %s_latency got %0d want 4", name, lat); else passed++;
        total++;
        if ({s, cout, ovf} !== exp)
            $display("FAIL %s_result got s=%h cout=%b ovf=%b want s=%h cout=%b ovf=%b",
                     name, s, cout, ovf, exp[17:2], exp[1], exp[0]);
        else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) drive(1'b1, va[i], vb[i], vc[i], vs[i]);
            else       drive(1'b0, 16'h5A5A, 16'hA5A5, 1'b0, 1'b1);
            tick();
            exp_v = (i >= 3 && i < 11);
            total++;
            if (out_valid !== exp_v) $display("FAIL b2b_valid cycle %0d got %b want %b", i, out_valid, exp_v);
            else if (exp_v && {s, cout, ovf} !== vexp[i-3])
                $display("FAIL b2b_beat%0d got s=%h cout=%b ovf=%b want %h", i-3, s, cout, ovf, vexp[i-3]);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        int   si = 0;
        int   ri = 0;
        logic ifire;
        logic ofire;
        for (int c = 0; c < 40 && ri < 8; c++) begin
            out_ready = !(c >= 6 && c <= 8);
            if (si < 8) drive(1'b1, va[si], vb[si], vc[si], vs[si]);
            else        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            #1;
            ifire = in_valid && in_ready;
            ofire = out_valid && out_ready;
            if (!out_ready && ri < 8) begin
                total++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || {s, cout, ovf} !== vexp[ri])
                    $display("FAIL bp_stall cycle %0d got in_ready=%b out_valid=%b s=%h want 0/1/%h",
                             c, in_ready, out_valid, s, vexp[ri][17:2]);
                else passed++;
            end
            if (ofire) begin
                total++;
                if ({s, cout, ovf} !== vexp[ri])
                    $display("FAIL bp_beat%0d got s=%h cout=%b ovf=%b want %h", ri, s, cout, ovf, vexp[ri]);
                else passed++;
                ri++;
            end
            tick();
            if (ifire) si++;
        end
        total++; if (ri !== 8) $display("FAIL bp_count got %0d want 8", ri); else passed++;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        total++; if (out_valid !== 1'b0) $display("FAIL bp_drained got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_reset_midstream();
        int seen = 0;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, va[i+3], vb[i+3], vc[i+3], vs[i+3]);
            tick();
        end
        rst = 1'b1;
        drive(1'b1, va[0], vb[0], vc[0], vs[0]);
        tick();
        rst = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        total++;
        if ({out_valid, s, cout, ovf} !== 19'h0)
            $display("FAIL midrst_outputs got valid=%b s=%h cout=%b ovf=%b want all 0", out_valid, s, cout, ovf);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        total++; if (seen !== 0) $display("FAIL midrst_ghost got %0d beats want 0", seen); else passed++;
        one_beat(16'h0003, 16'h0004, 1'b0, 1'b0, lat);
        total++; if (lat !== 4) $display("FAIL midrst_latency got %0d want 4", lat); else passed++;
        total++;
        if ({s, cout, ovf} !== {16'h0007, 1'b0, 1'b0})
            $display("FAIL midrst_result got s=%h cout=%b ovf=%b want 0007/0/0", s, cout, ovf);
        else passed++;
        tick();
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        test_reset();
        test_directed("carry_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0});
        test_directed("ovf_add",    16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1});
        test_directed("ovf_sub",    16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1});
        test_directed("borrow",     16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 1'b0, 1'b0});
        test_directed("borrow_cin", 16'h0005, 16'h0007, 1'b1, 1'b1, {16'hFFFD, 1'b0, 1'b0});
        test_directed("add_cin",    16'h0FFF, 16'h0000, 1'b1, 1'b0, {16'h1000, 1'b0, 1'b0});
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised successor to the team's 4-bit ripple-carry adder.
- W-bit adder/subtractor, split into CHUNK-bit ripple slices with one pipeline register per slice, so it closes timing at wide widths.
- Carries a valid/ready stream handshake with full backpressure.
- Used as the arithmetic front end of the datapath labs: operand stream in, result stream out.

Parameters:
- W, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per pipeline stage; STAGES = W/CHUNK (derived, not overridable).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts the beat this cycle.
- a  input  W  operand A (two's complement or unsigned).
- b  input  W  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts result.
- s  output  W  result.
- cout  output  1  carry-out (add); NOT borrow (sub): 1 = no borrow.
- ovf  output  1  signed overflow.

Behaviour:
- Reset (clk edge with rst=1):
  - All stage valid bits clear; out_valid=0, s=0, cout=0, ovf=0.
  - in_ready=1 in the first cycle after reset.
  - rst has priority over every other input, including mid-stream. In-flight beats are discarded, never emitted.
- Arithmetic:
  - add: {cout,s} = a + b + cin.
  - sub: {cout,s} = a + ~b + ~cin, i.e. a - b - cin.
  - ovf = (a_msb == b'_msb) && (s_msb != a_msb), where b' is b after the conditional invert.
  - Results are exact modulo 2^W; no saturation.
- Pipeline:
  - Stage k (0..STAGES-1) computes slice bits [k*CHUNK +: CHUNK] from the registered carry of stage k-1; stage 0 uses the effective carry-in.
  - Operand bits not yet consumed and result bits already produced travel with the beat in the stage registers.
  - Final-stage register drives s, cout, ovf, out_valid directly (registered outputs, no combinational path from inputs).
  - Latency: a beat accepted on cycle t appears with out_valid=1 at cycle t+STAGES, provided out_ready stayed high.
  - Throughput: one beat per cycle.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance.
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - On advance, every stage shifts one step: bubbles propagate as valid=0 and the whole pipe moves. Bubbles are not compressed.
  - When !advance, all stage registers hold. s/cout/ovf stay stable while out_valid=1 && out_ready=0.
  - in_valid=1 while in_ready=0: no beat consumed; the source must hold the operands.
  - Simultaneous in and out transfer on the same cycle is legal and is the steady state.
- Data in the a/b/cin/sub inputs is ignored when in_valid=0. Outputs do not change on idle cycles except the shift of bubbles.

Test Plan (W=16, CHUNK=4, latency 4):
1. Reset, then one beat: a=0xFFFF b=0x0001 cin=0 sub=0 -> 4 cycles later out_valid=1, s=0x0000, cout=1, ovf=0.
2. Signed overflow: a=0x7FFF b=0x0001 add -> s=0x8000 cout=0 ovf=1. Then a=0x8000 b=0x0001 sub -> s=0x7FFF cout=1 ovf=1.
3. Subtract with borrow: a=0x0005 b=0x0007 cin=0 sub=1 -> s=0xFFFE cout=0 ovf=0. Same operands with cin=1 -> s=0xFFFD.
4. Back-to-back stream of 8 random beats, out_ready=1 throughout -> 8 consecutive out_valid cycles, results in order, each matching a reference model.
5. Backpressure: stream 8 beats, drop out_ready for 3 cycles mid-stream -> in_ready=0 during the stall, s held stable, no beat lost or duplicated, order preserved.
6. Reset mid-stream with 3 beats in flight -> next cycle out_valid=0, outputs zero, none of the 3 beats ever emitted. A new beat afterwards completes with latency 4.
